// File: rtl/uc_runctl.sv
// uc_runctl: opcode decode plus start/stop/single-step/halt run control for the 8-bit microcontroller.
// Define UC_ICOUNT_EN to build the ICW-bit retired-instruction counter; otherwise icount reads 0.
module uc_runctl #(
   parameter int ICW = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [5:0]     opcode,
   input  logic           z,
   input  logic           start,
   input  logic           stop,
   input  logic           step,
   output logic           pc_en,
   output logic           s_inc,
   output logic           s_inm,
   output logic           we3,
   output logic           wez,
   output logic [2:0]     op,
   output logic           busy,
   output logic           halted,
   output logic [ICW-1:0] icount
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2,
      HALT = 2'd3
   } state_t;

   state_t state;
   logic   d_we3;
   logic   d_wez;
   logic   is_halt;
   logic   exec;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no decode path can infer a latch.
      s_inc   = 1'b0;
      s_inm   = 1'b0;
      op      = 3'b000;
      d_we3   = 1'b0;
      d_wez   = 1'b0;
      is_halt = 1'b0;
      if (!opcode[5]) begin
         op    = opcode[4:2];
         d_we3 = 1'b1;
         d_wez = 1'b1;
      end else if (opcode[5:2] == 4'b1000) begin
         s_inm = 1'b1;
         d_we3 = 1'b1;
      end else begin
         case (opcode)
            6'b100100: s_inc   = 1'b1;
            6'b100101: s_inc   = z;
            6'b100110: s_inc   = ~z;
            6'b111111: is_halt = 1'b1;
            default:   s_inc   = 1'b0;
         endcase
      end
   end

   // An exec cycle retires the presented instruction; reset and HALT opcodes never retire.
   always_comb begin
      exec = 1'b0;
      if (!reset) begin
         case (state)
            RUN:     exec = !stop && !is_halt;
            STEP:    exec = !is_halt;
            default: exec = 1'b0;
         endcase
      end
   end

   assign pc_en = exec;
   assign we3   = d_we3 & exec;
   assign wez   = d_wez & exec;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end else if (step) begin
                  state <= STEP;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (is_halt) begin
                  state  <= HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end
            end
            STEP: begin
               busy <= 1'b0;
               if (is_halt) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            HALT: begin
               state  <= HALT;
               busy   <= 1'b0;
               halted <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

`ifdef UC_ICOUNT_EN
   logic [ICW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (exec) begin
         count <= count + ICW'(1);
      end
   end

   assign icount = count;
`else
   assign icount = '0;
`endif

endmodule

// File: tb/tb_uc_runctl.sv
// Scoreboard bench for uc_runctl: directed vectors push hand-computed responses, a negedge monitor compares.
module tb_uc_runctl;

   localparam int ICW = 4;

   localparam logic [5:0] ALU = 6'b000100;
   localparam logic [5:0] LI  = 6'b100000;
   localparam logic [5:0] JMP = 6'b100100;
   localparam logic [5:0] JZ  = 6'b100101;
   localparam logic [5:0] JNZ = 6'b100110;
   localparam logic [5:0] HLT = 6'b111111;
   localparam logic [5:0] NOP = 6'b101000;

   logic           clk = 1'b0;
   logic           reset;
   logic [5:0]     opcode;
   logic           z;
   logic           start;
   logic           stop;
   logic           step;
   logic           pc_en;
   logic           s_inc;
   logic           s_inm;
   logic           we3;
   logic           wez;
   logic [2:0]     op;
   logic           busy;
   logic           halted;
   logic [ICW-1:0] icount;

   always #5 clk = ~clk;

   uc_runctl #(.ICW(ICW)) dut (
      .clk    (clk),
      .reset  (reset),
      .opcode (opcode),
      .z      (z),
      .start  (start),
      .stop   (stop),
      .step   (step),
      .pc_en  (pc_en),
      .s_inc  (s_inc),
      .s_inm  (s_inm),
      .we3    (we3),
      .wez    (wez),
      .op     (op),
      .busy   (busy),
      .halted (halted),
      .icount (icount)
   );

   typedef struct packed {
      logic           pc_en;
      logic           s_inc;
      logic           s_inm;
      logic           we3;
      logic           wez;
      logic [2:0]     op;
      logic           busy;
      logic           halted;
      logic [ICW-1:0] icount;
   } resp_t;

   typedef struct {
      int    idx;
      resp_t exp;
   } item_t;

   item_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    vec_no = 0;

   task automatic check(input string name, input resp_t act, input resp_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got pc_en=%b s_inc=%b s_inm=%b we3=%b wez=%b op=%b busy=%b halted=%b icount=%0d, expected pc_en=%b s_inc=%b s_inm=%b we3=%b wez=%b op=%b busy=%b halted=%b icount=%0d",
                  name, act.pc_en, act.s_inc, act.s_inm, act.we3, act.wez, act.op, act.busy, act.halted, act.icount,
                  exp.pc_en, exp.s_inc, exp.s_inm, exp.we3, exp.wez, exp.op, exp.busy, exp.halted, exp.icount);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         item_t it;
         resp_t act;
         it  = sb.pop_front();
         act = '{pc_en, s_inc, s_inm, we3, wez, op, busy, halted, icount};
         check($sformatf("vec%0d", it.idx), act, it.exp);
      end
   end

   // Drive one cycle of inputs and queue the response expected during that same cycle.
   task automatic vec(input logic r, input logic [5:0] opc, input logic zz,
                      input logic sta, input logic sto, input logic stp,
                      input logic e_pc, input logic e_si, input logic e_sm,
                      input logic e_w3, input logic e_wz, input logic [2:0] e_op,
                      input logic e_busy, input logic e_halt, input int e_ic);
      item_t it;
      reset  = r;
      opcode = opc;
      z      = zz;
      start  = sta;
      stop   = sto;
      step   = stp;
      it.idx = vec_no;
`ifdef UC_ICOUNT_EN
      it.exp = '{e_pc, e_si, e_sm, e_w3, e_wz, e_op, e_busy, e_halt, ICW'(e_ic % (1 << ICW))};
`else
      it.exp = '{e_pc, e_si, e_sm, e_w3, e_wz, e_op, e_busy, e_halt, ICW'(0)};
`endif
      sb.push_back(it);
      vec_no++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset  = 1'b1;
      opcode = NOP;
      z      = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      step   = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Idle after reset: decode visible, nothing executes.
      repeat (5) vec(0, ALU, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b001, 0, 0, 0);

      // start pulse, then LI / ALU / HALT program; HALT ignores start/step/stop; reset leaves it.
      vec(0, NOP, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      vec(0, LI,  0, 0, 0, 0,  1, 0, 1, 1, 0, 3'b000, 1, 0, 0);
      vec(0, ALU, 0, 0, 0, 0,  1, 0, 0, 1, 1, 3'b001, 1, 0, 1);
      vec(0, HLT, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 1, 0, 2);
      vec(0, ALU, 0, 1, 1, 1,  0, 0, 0, 0, 0, 3'b001, 0, 1, 2);
      vec(0, NOP, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 1, 2);
      vec(1, ALU, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b001, 0, 1, 2);

      // Conditional jumps in RUN.
      vec(0, NOP, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      vec(0, JZ,  1, 0, 0, 0,  1, 1, 0, 0, 0, 3'b000, 1, 0, 0);
      vec(0, JZ,  0, 0, 0, 0,  1, 0, 0, 0, 0, 3'b000, 1, 0, 1);
      vec(0, JNZ, 1, 0, 0, 0,  1, 0, 0, 0, 0, 3'b000, 1, 0, 2);
      vec(0, JNZ, 0, 0, 0, 0,  1, 1, 0, 0, 0, 3'b000, 1, 0, 3);
      vec(0, JMP, 0, 0, 0, 0,  1, 1, 0, 0, 0, 3'b000, 1, 0, 4);

      // stop on an ALU op blocks its exec; stop beats HALT.
      vec(0, ALU, 0, 0, 1, 0,  0, 0, 0, 0, 0, 3'b001, 1, 0, 5);
      vec(0, ALU, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b001, 0, 0, 5);
      vec(0, NOP, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 5);
      vec(0, HLT, 0, 0, 1, 0,  0, 0, 0, 0, 0, 3'b000, 1, 0, 5);
      vec(0, NOP, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 5);

      // step held for 6 cycles: exec every other cycle, stop ignored in STEP.
      vec(0, ALU, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3'b001, 0, 0, 5);
      vec(0, ALU, 0, 0, 0, 1,  1, 0, 0, 1, 1, 3'b001, 1, 0, 5);
      vec(0, ALU, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3'b001, 0, 0, 6);
      vec(0, ALU, 0, 0, 1, 1,  1, 0, 0, 1, 1, 3'b001, 1, 0, 6);
      vec(0, ALU, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3'b001, 0, 0, 7);
      vec(0, ALU, 0, 0, 0, 1,  1, 0, 0, 1, 1, 3'b001, 1, 0, 7);
      vec(0, NOP, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 8);

      // start beats step; HALT reached from STEP; reset clears HALT.
      vec(0, NOP, 0, 1, 0, 1,  0, 0, 0, 0, 0, 3'b000, 0, 0, 8);
      vec(0, NOP, 0, 0, 0, 1,  1, 0, 0, 0, 0, 3'b000, 1, 0, 8);
      vec(0, NOP, 0, 0, 1, 0,  0, 0, 0, 0, 0, 3'b000, 1, 0, 9);
      vec(0, NOP, 0, 0, 0, 1,  0, 0, 0, 0, 0, 3'b000, 0, 0, 9);
      vec(0, HLT, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 1, 0, 9);
      vec(0, NOP, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 1, 9);
      vec(1, NOP, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 1, 9);

      // 16 execs wrap the 4-bit counter; then reset mid-RUN.
      vec(0, NOP, 0, 1, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         vec(0, NOP, 0, 0, 0, 0,  1, 0, 0, 0, 0, 3'b000, 1, 0, i);
      end
      vec(0, ALU, 0, 0, 0, 0,  1, 0, 0, 1, 1, 3'b001, 1, 0, 16);
      vec(1, ALU, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b001, 1, 0, 17);
      vec(0, NOP, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 0, 0, 0);

      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uc_runctl.md
# uc_runctl

Control unit with run control for the 8-bit single-cycle microcontroller. It decodes the 6-bit opcode and the registered zero flag into datapath controls (`s_inc`, `s_inm`, `we3`, `wez`, `op`) plus a PC load enable. It adds a start/stop/single-step/halt state machine and an optional retired-instruction counter. It sits beside the datapath in the processor top and drives every control input the datapath exposes.

## Interface
- `ICW`, 16, width of retired-instruction counter
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock, sampled on rising edge of `clk`
- `opcode`  in  6  current instruction bits [15:10] from the datapath
- `z`  in  1  registered zero flag from the datapath
- `start`  in  1  level; begin free-running execution
- `stop`  in  1  level; return to IDLE
- `step`  in  1  level; execute exactly one instruction from IDLE
- `pc_en`  out  1  PC register load enable; 0 holds PC
- `s_inc`  out  1  PC mux select: 0 = PC+1, 1 = instr[9:0] jump target
- `s_inm`  out  1  1 = immediate path (ALU operand A = instr[7:0], write address = instr[3:0])
- `we3`  out  1  register-file write enable
- `wez`  out  1  zero-flag write enable
- `op`  out  3  ALU operation
- `busy`  out  1  1 in RUN or STEP
- `halted`  out  1  1 in HALT
- `icount`  out  ICW  retired-instruction count

## Operation
- Decode (combinational from `opcode`, `z`):
  - `opcode[5]=0`: ALU op; `op=opcode[4:2]`, `we3=1`, `wez=1`, `s_inm=0`, `s_inc=0`.
  - `opcode[5:2]=1000`: load immediate; `s_inm=1`, `op=000` (pass A), `we3=1`, `wez=0`, `s_inc=0`.
  - `100100` J: `s_inc=1`. `100101` JZ: `s_inc=z`. `100110` JNZ: `s_inc=~z`. No writes.
  - `111111` HALT. Every other opcode is a NOP: PC+1, no writes.
- Gating: decoded `we3`, `wez`, and `pc_en=1` reach the outputs only when the current state executes the instruction (the "exec" cycle). Outside an exec cycle, `pc_en=we3=wez=0`. `s_inc`, `s_inm`, and `op` still reflect the decode.
- The HALT opcode never executes: `pc_en=0` and no writes.
- FSM states:
  - IDLE (reset state): no exec.
    - `start`: go to RUN.
    - else `step`: go to STEP.
    - `start` has priority over `step`.
  - RUN: exec every cycle unless `stop=1` or the opcode is HALT.
    - `stop=1`: no exec that cycle; go to IDLE. `stop` has priority over HALT.
    - HALT opcode: go to HALT.
  - STEP: one exec cycle, then back to IDLE.
    - HALT opcode in STEP: no exec; go to HALT.
    - `stop` is ignored in STEP.
  - HALT: no exec. Exit only by `reset`. `start`, `step`, and `stop` are ignored.
- `icount`: +1 on each exec cycle. Wraps from all-ones to 0.

## Timing
- Decode-to-control is purely combinational, with zero latency within the cycle.
- State, `icount`, `busy`, and `halted` are registered.
- `start`/`step` sampled at edge N: first exec is cycle N+1.
- `stop` sampled in cycle N: cycle N does not exec; IDLE from N+1.
- `step` held high: one instruction per two cycles (IDLE, STEP, IDLE, ...).
- `reset` has priority over everything. Reset mid-RUN: state IDLE, `icount=0`, `busy=0`, `halted=0`.
  - Outputs during the reset cycle: `pc_en=we3=wez=0`.
- The PC register itself is reset by the datapath, not by this block.
- JZ/JNZ use `z` as registered at the previous edge. A JZ immediately after an ALU op sees that op's result flag.

## Configuration
- `UC_ICOUNT_EN`:
  - Defined: the `ICW`-bit retired-instruction counter is implemented as above.
  - Undefined: no counter register; `icount` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then hold `start=0`, `step=0` for 5 cycles -> IDLE; `pc_en=we3=wez=0`, `busy=0`, `icount=0`.
- `start` pulse; program: LI 0x05, ALU op `opcode=000100`, then HALT:
  - cycle 1: `s_inm=1`, `we3=1`, `wez=0`
  - cycle 2: `op=001`, `we3=1`, `wez=1`
  - cycle 3: `pc_en=0`
  - then `halted=1`, `icount=2`.
- RUN with JZ (`100101`), `z=1` -> `s_inc=1`, `pc_en=1`. Same with `z=0` -> `s_inc=0`. JNZ gives the inverse.
- RUN, assert `stop` on the cycle an ALU op is presented -> `we3=0`, `pc_en=0` that cycle; IDLE next; `icount` unchanged.
- From IDLE, hold `step` for 6 cycles -> exactly 3 exec cycles; `icount` +3; `busy` pattern 0,1,0,1,0,1.
- With `UC_ICOUNT_EN`, `ICW=4`, 16 execs from 0 -> `icount=0` (wrap). Without the macro -> `icount=0` throughout.
